// File: rtl/dff_sync_pipe_pkg.sv
// dff_pkg: width helpers shared by the selectable register pipeline
package dff_pkg;
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int count_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dff_sync_pipe_stage.sv
// pipe_stage: one elastic register stage with valid bit, reset/flush to VAL
module pipe_stage #(
  parameter int N = 4,
  parameter logic [N-1:0] VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         v_i,
  input  logic [N-1:0] d_i,
  input  logic         rdy_i,
  output logic         v_o,
  output logic [N-1:0] d_o,
  output logic         rdy_o
);
  logic v_q, v_d;
  logic [N-1:0] d_q, d_d;
  // accept upstream beat when empty or draining; data loads even for bubbles
  always_comb begin
    rdy_o = !v_q || rdy_i;
    v_d   = flush_i ? 1'b0 : rdy_o ? v_i : v_q;
    d_d   = flush_i ? VAL  : rdy_o ? d_i : d_q;
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      v_q <= 1'b0;
      d_q <= VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
  assign v_o = v_q;
  assign d_o = d_q;
endmodule

// File: rtl/dff_sync_pipe.sv
// dff_sync_pipe: source select feeding a DEPTH-stage valid/ready register pipeline
module dff_sync_pipe
  import dff_pkg::*;
#(
  parameter int N = 4,
  parameter int N_SRC = 2,
  parameter int DEPTH = 1,
  parameter logic [N-1:0] VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SRC-1:0][N-1:0]    data_i,
  input  logic [sel_w(N_SRC)-1:0]    sel_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  output logic [N-1:0]               y_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [count_w(DEPTH)-1:0]  count_o
);
  localparam int SELW = sel_w(N_SRC);
  localparam int CW = count_w(DEPTH);
  logic [N-1:0] sel_word;
  logic [DEPTH:0] v, rdy;
  logic [DEPTH:0][N-1:0] d;
  logic in_xfer, out_xfer;
  logic [CW-1:0] count_q, count_d;
  // out-of-range indices fall through to VAL
  always_comb begin
    sel_word = VAL;
    for (int k = 0; k < N_SRC; k++) sel_word = (sel_i == SELW'(k)) ? data_i[k] : sel_word;
  end
  assign v[0]       = valid_i;
  assign d[0]       = sel_word;
  assign rdy[DEPTH] = ready_i;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(.N(N), .VAL(VAL)) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .v_i     (v[g]),
      .d_i     (d[g]),
      .rdy_i   (rdy[g+1]),
      .v_o     (v[g+1]),
      .d_o     (d[g+1]),
      .rdy_o   (rdy[g])
    );
  end
  assign ready_o = rdy[0];
  assign valid_o = v[DEPTH];
  assign y_o     = d[DEPTH];
  // occupancy tracks transfers at both ends; flush empties it
  always_comb begin
    in_xfer  = valid_i && rdy[0];
    out_xfer = v[DEPTH] && ready_i;
    count_d  = flush_i ? '0 : count_q + CW'(in_xfer) - CW'(out_xfer);
  end
  // occupancy register
  always_ff @(posedge clk_i) begin
    if (!rst_i) count_q <= '0;
    else count_q <= count_d;
  end
  assign count_o = count_q;
endmodule

// File: tb/tb_dff_sync_pipe.sv
// tb_dff_sync_pipe: randomized and directed checks against a queue model
module tb_dff_sync_pipe;
  logic clk = 0;
  logic rst_i = 1, flush_i = 0, valid_i = 0, ready_i = 1;
  logic [3:0][7:0] data_i = '0;
  logic [1:0] sel_i = 0;
  logic ready_o, valid_o;
  logic [7:0] y_o;
  logic [1:0] count_o;
  logic [2:0][7:0] data3 = '0;
  logic [1:0] sel3 = 0;
  logic valid3 = 0, ready3 = 1, flush3 = 0;
  logic ready3_o, valid3_o;
  logic [7:0] y3;
  logic count3;
  int tests = 0, fails = 0;
  bit mon_en = 0;
  logic [7:0] q[$];
  bit stall_prev = 0;
  logic [7:0] y_prev;
  bit exp_rdy;

  always #5 clk = ~clk;

  dff_sync_pipe #(.N(8), .N_SRC(4), .DEPTH(3), .VAL(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .sel_i(sel_i), .valid_i(valid_i),
    .ready_o(ready_o), .flush_i(flush_i), .y_o(y_o), .valid_o(valid_o),
    .ready_i(ready_i), .count_o(count_o));

  dff_sync_pipe #(.N(8), .N_SRC(3), .DEPTH(1), .VAL(8'hA5)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data3), .sel_i(sel3), .valid_i(valid3),
    .ready_o(ready3_o), .flush_i(flush3), .y_o(y3), .valid_o(valid3_o),
    .ready_i(ready3), .count_o(count3));

  // reference: FIFO of accepted beats; occupancy = size, ready = not full or draining
  always @(posedge clk) if (mon_en) begin
    exp_rdy = (q.size() < 3) || ready_i;
    tests++;
    if (count_o !== 2'(q.size())) begin fails++; $display("FAIL mon_count got %0d exp %0d", count_o, q.size()); end
    tests++;
    if (ready_o !== exp_rdy) begin fails++; $display("FAIL mon_ready got %b exp %b", ready_o, exp_rdy); end
    if (valid_o === 1'b1) begin
      tests++;
      if (q.size() == 0 || y_o !== q[0]) begin fails++; $display("FAIL mon_y got %h exp %h (qsize %0d)", y_o, q.size() ? q[0] : 8'h00, q.size()); end
    end
    if (stall_prev) begin
      tests++;
      if (valid_o !== 1'b1 || y_o !== y_prev) begin fails++; $display("FAIL mon_stable got v=%b y=%h exp v=1 y=%h", valid_o, y_o, y_prev); end
    end
    stall_prev = rst_i && !flush_i && valid_o && !ready_i;
    y_prev = y_o;
    if (!rst_i) q.delete();
    else begin
      if (valid_o && ready_i && q.size() > 0) void'(q.pop_front());
      if (flush_i) q.delete();
      else if (valid_i && exp_rdy) q.push_back(data_i[sel_i]);
    end
  end

  task automatic drain();
    valid_i = 0; ready_i = 1; flush_i = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 0;
    repeat (2) @(negedge clk);
    rst_i = 1;
    mon_en = 1;
    #1;
    tests++; if (y_o !== 8'hA5) begin fails++; $display("FAIL rst_y got %h exp a5", y_o); end
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", valid_o); end
    tests++; if (count_o !== 2'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", ready_o); end
    tests++; if (y3 !== 8'hA5 || valid3_o !== 1'b0 || count3 !== 1'b0) begin fails++; $display("FAIL rst_dut3 got y=%h v=%b c=%b exp a5 0 0", y3, valid3_o, count3); end
  endtask

  task automatic test_stream();
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    sel_i = 2; valid_i = 1; ready_i = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests++;
      if (valid_o !== (k >= 3)) begin fails++; $display("FAIL stream_valid edge %0d got %b exp %b", k, valid_o, k >= 3); end
      if (k >= 3) begin
        tests++; if (y_o !== 8'h33) begin fails++; $display("FAIL stream_y edge %0d got %h exp 33", k, y_o); end
      end
      tests++;
      if (count_o !== 2'(k < 3 ? k : 3)) begin fails++; $display("FAIL stream_count edge %0d got %0d exp %0d", k, count_o, k < 3 ? k : 3); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] outs[$];
    int idx = 0, phase = 0, stall = 0;
    data_i = '0; sel_i = 0; ready_i = 1;
    for (int c = 0; c < 40 && outs.size() < 4; c++) begin
      @(negedge clk);
      if (phase == 0 && valid_o && y_o == 8'h01) begin
        ready_i = 0; phase = 1;
      end else if (phase == 1) begin
        stall++;
        tests++;
        if (ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready stall %0d got %b exp 0", stall, ready_o); end
        if (stall == 5) begin
          tests++; if (count_o !== 2'd3) begin fails++; $display("FAIL bp_count got %0d exp 3", count_o); end
          tests++; if (valid_o !== 1'b1 || y_o !== 8'h01) begin fails++; $display("FAIL bp_hold got v=%b y=%h exp 1 01", valid_o, y_o); end
          ready_i = 1; phase = 2;
        end
      end
      valid_i = idx < 4;
      data_i[0] = 8'(idx + 1);
      #1;
      if (valid_o && ready_i) outs.push_back(y_o);
      if (valid_i && ready_o) idx++;
    end
    valid_i = 0;
    tests++;
    if (outs.size() != 4) begin fails++; $display("FAIL bp_outcount got %0d exp 4", outs.size()); end
    for (int i = 0; i < outs.size() && i < 4; i++) begin
      tests++;
      if (outs[i] !== 8'(i + 1)) begin fails++; $display("FAIL bp_order[%0d] got %h exp %h", i, outs[i], 8'(i + 1)); end
    end
    drain();
  endtask

  task automatic test_full_simul();
    ready_i = 0; sel_i = 1; valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      data_i[1] = 8'(8'h10 + i);
      @(negedge clk);
    end
    data_i[1] = 8'h20;
    #1;
    tests++; if (count_o !== 2'd3 || ready_o !== 1'b0) begin fails++; $display("FAIL full_stall got c=%0d r=%b exp 3 0", count_o, ready_o); end
    @(negedge clk);
    ready_i = 1;
    #1;
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL full_ready got %b exp 1", ready_o); end
    tests++; if (y_o !== 8'h10) begin fails++; $display("FAIL full_head got %h exp 10", y_o); end
    @(negedge clk);
    valid_i = 0;
    tests++; if (count_o !== 2'd3) begin fails++; $display("FAIL full_count got %0d exp 3", count_o); end
    tests++; if (y_o !== 8'h11) begin fails++; $display("FAIL full_next got %h exp 11", y_o); end
    drain();
  endtask

  task automatic test_sel_range();
    logic [7:0] exp;
    data_i = {8'h77, 8'h66, 8'h55, 8'h44};
    sel_i = 3; valid_i = 1; ready_i = 1;
    @(negedge clk);
    valid_i = 0;
    repeat (2) @(negedge clk);
    tests++; if (valid_o !== 1'b1 || y_o !== 8'h77) begin fails++; $display("FAIL sel3_n4 got v=%b y=%h exp 1 77", valid_o, y_o); end
    drain();
    data3 = {8'h33, 8'h22, 8'h11}; sel3 = 3; valid3 = 1; ready3 = 1;
    @(negedge clk);
    tests++; if (valid3_o !== 1'b1 || y3 !== 8'hA5) begin fails++; $display("FAIL sel3_n3 got v=%b y=%h exp 1 a5", valid3_o, y3); end
    for (int i = 0; i < 20; i++) begin
      sel3 = 2'($urandom_range(0, 3));
      data3 = {8'($urandom), 8'($urandom), 8'($urandom)};
      exp = 8'hA5;
      for (int k = 0; k < 3; k++) if (sel3 == 2'(k)) exp = data3[k];
      @(negedge clk);
      tests++; if (y3 !== exp) begin fails++; $display("FAIL sel_rand_n3 sel %0d got %h exp %h", sel3, y3, exp); end
    end
    valid3 = 0;
  endtask

  task automatic test_flush();
    ready_i = 0; sel_i = 0; valid_i = 1;
    data_i[0] = 8'h51;
    @(negedge clk);
    data_i[0] = 8'h52;
    @(negedge clk);
    valid_i = 0;
    tests++; if (count_o !== 2'd2) begin fails++; $display("FAIL flush_pre got %0d exp 2", count_o); end
    flush_i = 1; valid_i = 1; data_i[0] = 8'hEE;
    #1;
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready got %b exp 1", ready_o); end
    @(negedge clk);
    flush_i = 0; valid_i = 0;
    tests++; if (count_o !== 2'd0 || valid_o !== 1'b0 || y_o !== 8'hA5) begin fails++; $display("FAIL flush_state got c=%0d v=%b y=%h exp 0 0 a5", count_o, valid_o, y_o); end
    ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_ghost cycle %0d got %b exp 0", i, valid_o); end
    end
  endtask

  task automatic test_reset_mid_stall();
    ready_i = 0; sel_i = 0; valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      data_i[0] = 8'(8'hC0 + i);
      @(negedge clk);
    end
    rst_i = 0;
    @(negedge clk);
    rst_i = 1; valid_i = 0;
    #1;
    tests++; if (count_o !== 2'd0 || valid_o !== 1'b0 || y_o !== 8'hA5 || ready_o !== 1'b1) begin fails++; $display("FAIL rst_stall got c=%0d v=%b y=%h r=%b exp 0 0 a5 1", count_o, valid_o, y_o, ready_o); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      valid_i = 1'($urandom_range(0, 1));
      ready_i = $urandom_range(0, 3) != 0;
      sel_i = 2'($urandom_range(0, 3));
      data_i = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      flush_i = $urandom_range(0, 39) == 0;
      rst_i = !($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst_i = 1;
    drain();
    tests++; if (count_o !== 2'd0 || valid_o !== 1'b0) begin fails++; $display("FAIL rand_drain got c=%0d v=%b exp 0 0", count_o, valid_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_simul();
    test_sel_range();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dff_sync_pipe.md
# dff_sync_pipe

Parametrised successor to the two-input selectable register: it selects one of `N_SRC` data sources by index and carries the result through a `DEPTH`-stage elastic register pipeline. The pipeline has valid/ready backpressure, a synchronous flush and an occupancy count. Every stage resets and flushes to `VAL`. It sits between datapath producers, such as SHA-256 round or message-schedule sources, and a consumer that may stall.

## Interface
Parameters:
- `N`, default 4: data width in bits (≥1).
- `N_SRC`, default 2: number of selectable sources (≥2).
- `DEPTH`, default 1: number of register stages (≥1).
- `VAL`, default `'0`: reset/flush value of every stage's data register, `N` bits.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_i`, in, 1: synchronous, active-low reset.
- `data_i`, in, `N_SRC`×`N` packed array: source data; `data_i[k]` is source k.
- `sel_i`, in, `SELW = max(1,$clog2(N_SRC))`: source index.
- `valid_i`, in, 1: input beat valid.
- `ready_o`, out, 1: pipeline can accept an input beat this cycle.
- `flush_i`, in, 1: synchronous clear of all stages.
- `y_o`, out, `N`: last-stage data.
- `valid_o`, out, 1: last-stage data valid.
- `ready_i`, in, 1: consumer accepts `y_o` this cycle.
- `count_o`, out, `$clog2(DEPTH+1)`: number of valid stages, from 0 to `DEPTH`.

## Operation
- Source select:
  - Selected word is `data_i[sel_i]`.
  - If `sel_i ≥ N_SRC`, the selected word is `VAL`; this is not an error.
- Per stage s (0 = input side, `DEPTH-1` = output side):
  - State is `v[s]` and `d[s]`.
  - Stage s is ready when `!v[s] || ready[s+1]`; `ready[DEPTH]` is `ready_i`.
- Ready chain:
  - The chain is combinational, so bubbles collapse and full throughput is one beat per cycle.
  - `ready_o = ready[0]`.
- Stage advance, when stage s is ready:
  - `v[s] <= v[s-1]` and `d[s] <= d[s-1]`.
  - For stage 0 the sources are `valid_i` and the selected word.
- Data on stall or empty:
  - A stage that is not ready holds `d[s]` and `v[s]` unchanged.
  - When a stage receives an invalid beat, its data register still loads, keeping the datapath enable-free; `y_o` is a don't-care when `valid_o`=0.
- Outputs: `y_o = d[DEPTH-1]`, `valid_o = v[DEPTH-1]`.
- Handshake rules:
  - Input transfer happens when `valid_i && ready_o`; output transfer happens when `valid_o && ready_i`.
  - Once `valid_o` is asserted, it stays asserted and `y_o` stays stable until the output transfer.
- `count_o`:
  - Registered counter.
  - +1 on an input transfer only, −1 on an output transfer only, unchanged when both or neither occur.
  - Must always equal the popcount of `v`.

## Timing
- Reset (`rst_i`=0 at an edge):
  - All `v` cleared, all `d` set to `VAL`, `count_o` set to 0.
  - Outputs after reset: `y_o`=`VAL`, `valid_o`=0, `count_o`=0, `ready_o`=1.
  - Reset overrides flush and any transfer in the same cycle.
- Flush (`flush_i`=1 at an edge, `rst_i`=1):
  - Same effect as reset.
  - An input beat presented in that cycle is dropped, and a concurrent output transfer still counts as consumed.
  - `ready_o` does not depend on `flush_i`.
- Latency:
  - An input accepted at edge t appears with `valid_o`=1 after edge t+`DEPTH`−1, i.e. visible in the cycle after `DEPTH` edges counted from acceptance, when there is no stall.
  - `DEPTH`=1 behaves like the original selectable register plus handshake.
- Throughput: one beat per cycle while `ready_i`=1.
- Full pipeline: when `count_o`=`DEPTH` and `ready_i`=0, `ready_o`=0.
- Simultaneous events:
  - When full with `ready_i`=1, `ready_o`=1 in the same cycle; the input and output transfers happen together and `count_o` is unchanged.
- Reset mid-stall: in-flight data is discarded and the next cycle behaves as after reset.

## Structure
- Package `dff_pkg` holds a `clog2`-safe width function `sel_w(n)` (returns ≥1) and a `count_w(depth)` helper.
- Sub-module `pipe_stage`:
  - Holds one valid bit and an `N`-bit register with reset/flush value `VAL`.
  - Ports: `clk_i`, `rst_i`, `flush_i`, `v_i`, `d_i`, `rdy_i`, `v_o`, `d_o`, `rdy_o`.
  - Instantiated `DEPTH` times by a generate loop.
- The top level contains the source mux, the ready-chain wiring and the `count_o` counter.

## Test plan
Parameters for all scenarios: `N`=8, `N_SRC`=4, `DEPTH`=3, `VAL`=8'hA5.
- Reset, then idle:
  - Stimulus: `rst_i` low for 2 edges.
  - Required: `y_o`=A5, `valid_o`=0, `count_o`=0, `ready_o`=1.
- Streaming:
  - Stimulus: `data_i`={44,33,22,11} with `sel_i`=2, `valid_i`=1, `ready_i`=1 for 5 cycles.
  - Required: `valid_o` rises 3 cycles after the first accept with `y_o`=33, then one beat per cycle; `count_o` settles at 3.
- Backpressure:
  - Stimulus: stream beats 01,02,03,04; hold `ready_i`=0 from the cycle `y_o`=01 appears.
  - Required: `ready_o`=0 once `count_o`=3, `y_o` holds 01; beat 04 is held off until `ready_i` returns to 1.
  - Required: on release, output order is 01,02,03,04 with no loss or duplication.
- Full plus simultaneous accept:
  - Stimulus: pipeline full, `ready_i`=1 and `valid_i`=1 in one cycle.
  - Required: one output and one input transfer; `count_o` stays 3.
- Out-of-range select: `sel_i`=3 is valid for `N_SRC`=4 and delivers `data_i[3]`; with `N_SRC`=3, `sel_i`=3 delivers A5.
- Flush mid-stall:
  - Stimulus: `count_o`=2, `flush_i`=1 with `valid_i`=1.
  - Required: next cycle `count_o`=0, `valid_o`=0, `y_o`=A5, and the flushed input never appears.
- Checker: `count_o` equals the valid popcount on every cycle; `y_o` is stable while `valid_o && !ready_i`.
